// File: rtl/demux12_stream.sv
// Packet-aware 1-to-2 stream demultiplexer with a small FIFO per output channel.
// Define DEMUX12_STATS_EN to add per-channel pop counters (out1_cnt, out2_cnt).
module demux12_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             s,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_last,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX12_STATS_EN
    ,
    output logic [CNT_W-1:0] out1_cnt,
    output logic [CNT_W-1:0] out2_cnt
`endif
);

    // state | meaning
    // IDLE  | between packets; route follows s
    // PKT   | mid-packet; route held in lock_sel until the last beat
    typedef enum logic {IDLE, PKT} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    state_t         state;
    logic           lock_sel;
    logic           route_sel;
    logic           accept;
    logic [AW:0]    wptr [2];
    logic [AW:0]    rptr [2];
    logic [WIDTH:0] mem  [2][DEPTH];
    logic [WIDTH:0] head [2];
    logic [1:0]     full;
    logic [1:0]     empty;
    logic [1:0]     push;
    logic [1:0]     pop;

    always_comb begin
        route_sel = (state == IDLE) ? s : lock_sel;
        for (int c = 0; c < 2; c++) begin
            empty[c] = (wptr[c] == rptr[c]);
            full[c]  = (wptr[c][AW] != rptr[c][AW]) &&
                       (wptr[c][AW-1:0] == rptr[c][AW-1:0]);
            head[c]  = empty[c] ? '0 : mem[c][rptr[c][AW-1:0]];
        end
    end

    // Ready looks at full only, so a pop never frees space for a push in the same cycle.
    assign in_ready = rstb & ~full[route_sel];
    assign accept   = in_valid & in_ready;
    assign push     = {accept & route_sel, accept & ~route_sel};
    assign pop      = ~empty & {out2_ready, out1_ready};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            lock_sel <= 1'b0;
        end else if (accept) begin
            if (state == IDLE && !in_last) begin
                state    <= PKT;
                lock_sel <= s;
            end else if (state == PKT && in_last) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int c = 0; c < 2; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wptr[c] <= wptr[c] + PTR_ONE;
                if (pop[c])  rptr[c] <= rptr[c] + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: head is masked to zero while a FIFO is empty.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) mem[c][wptr[c][AW-1:0]] <= {in_last, in_data};
        end
    end

    assign out1_data  = head[0][WIDTH-1:0];
    assign out1_last  = head[0][WIDTH];
    assign out1_valid = ~empty[0];
    assign out2_data  = head[1][WIDTH-1:0];
    assign out2_last  = head[1][WIDTH];
    assign out2_valid = ~empty[1];

`ifdef DEMUX12_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out1_cnt <= '0;
            out2_cnt <= '0;
        end else begin
            if (pop[0]) out1_cnt <= out1_cnt + CNT_ONE;
            if (pop[1]) out2_cnt <= out2_cnt + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_demux12_stream.sv
// Directed plus random bench for demux12_stream against a queue-based packet model.
module tb_demux12_stream;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             s = 1'b0;
    logic [WIDTH-1:0] out1_data, out2_data;
    logic             out1_last, out1_valid, out2_last, out2_valid;
    logic             out1_ready = 1'b0;
    logic             out2_ready = 1'b0;
`ifdef DEMUX12_STATS_EN
    logic [CNT_W-1:0] out1_cnt, out2_cnt;
`endif

    always #5 clk = ~clk;

    demux12_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstb(rstb), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .s(s),
        .out1_data(out1_data), .out1_last(out1_last), .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_last(out2_last), .out2_valid(out2_valid),
        .out2_ready(out2_ready)
`ifdef DEMUX12_STATS_EN
        , .out1_cnt(out1_cnt), .out2_cnt(out2_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: one queue of {last,data} per channel, plus packet lock state.
    logic [WIDTH:0] q1[$];
    logic [WIDTH:0] q2[$];
    bit             in_pkt;
    bit             lk;
    int unsigned    cnt1, cnt2;
    bit             last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q2.delete();
        in_pkt = 0;
        lk     = 0;
        cnt1   = 0;
        cnt2   = 0;
    endtask

    task automatic cycle();
        bit             sel, room, acc, p1, p2;
        logic [WIDTH:0] h1, h2;
        @(negedge clk);
        sel  = in_pkt ? lk : s;
        room = sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
        acc  = in_valid && room;
        h1   = (q1.size() > 0) ? q1[0] : '0;
        h2   = (q2.size() > 0) ? q2[0] : '0;
        chk("in_ready",   in_ready,   room);
        chk("out1_valid", out1_valid, q1.size() > 0);
        chk("out1_data",  out1_data,  h1[WIDTH-1:0]);
        chk("out1_last",  out1_last,  h1[WIDTH]);
        chk("out2_valid", out2_valid, q2.size() > 0);
        chk("out2_data",  out2_data,  h2[WIDTH-1:0]);
        chk("out2_last",  out2_last,  h2[WIDTH]);
`ifdef DEMUX12_STATS_EN
        chk("out1_cnt", out1_cnt, cnt1);
        chk("out2_cnt", out2_cnt, cnt2);
`endif
        p1 = out1_ready && (q1.size() > 0);
        p2 = out2_ready && (q2.size() > 0);
        @(posedge clk);
        if (p1) begin void'(q1.pop_front()); cnt1 = (cnt1 + 1) % (1 << CNT_W); end
        if (p2) begin void'(q2.pop_front()); cnt2 = (cnt2 + 1) % (1 << CNT_W); end
        if (acc) begin
            if (sel) q2.push_back({in_last, in_data});
            else     q1.push_back({in_last, in_data});
            if (!in_pkt && !in_last) begin
                in_pkt = 1;
                lk     = s;
            end else if (in_pkt && in_last) begin
                in_pkt = 0;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] d, input logic l, input logic sl);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        s        = sl;
        cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rstb = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready",   in_ready,   1'b0);
        chk("rst_out1_valid", out1_valid, 1'b0);
        chk("rst_out2_valid", out2_valid, 1'b0);
        @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    initial begin
        model_reset();
        last_acc = 1;
        #2;
        chk("por_in_ready",   in_ready,   1'b0);
        chk("por_out1_valid", out1_valid, 1'b0);
        chk("por_out2_valid", out2_valid, 1'b0);
        chk("por_out1_data",  out1_data,  8'h00);
        @(posedge clk);
        #1 rstb = 1'b1;

        // Single-beat packet to channel 1
        out1_ready = 1; out2_ready = 1;
        drive(8'hA5, 1'b1, 1'b0);
        in_valid = 0;
        repeat (2) cycle();

        // 4-beat packet locked to channel 2 while s changes
        drive(8'h11, 1'b0, 1'b1);
        drive(8'h22, 1'b0, 1'b0);
        drive(8'h33, 1'b0, 1'b0);
        drive(8'h44, 1'b1, 1'b0);
        in_valid = 0;
        repeat (3) cycle();

        // Fill channel 1, stall, then a new packet to channel 2 still gets through
        out1_ready = 0;
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0);
        drive(8'h04, 1'b1, 1'b1);
        in_valid = 0;
        cycle();

        // Full channel 1 with a pop: no accept that cycle, accept on the next
        out1_ready = 1;
        drive(8'h03, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0);
        in_valid = 0;
        repeat (4) cycle();

        // Asynchronous reset after beat 2 of 4
        drive(8'hA1, 1'b0, 1'b0);
        drive(8'hA2, 1'b0, 1'b0);
        in_valid = 0;
        rstb = 1'b0;
        #1;
        chk("midrst_out1_valid", out1_valid, 1'b0);
        chk("midrst_out2_valid", out2_valid, 1'b0);
        chk("midrst_in_ready",   in_ready,   1'b0);
        model_reset();
        @(posedge clk);
        #1 rstb = 1'b1;
        drive(8'h5C, 1'b1, 1'b1);
        in_valid = 0;
        repeat (2) cycle();

`ifdef DEMUX12_STATS_EN
        do_reset();
        out1_ready = 1;
        for (int i = 0; i < 17; i++) drive(WIDTH'(i), 1'b1, 1'b0);
        in_valid = 0;
        repeat (2) cycle();
        chk("cnt1_wrap", out1_cnt, 1);
        chk("cnt2_idle", out2_cnt, 0);
`endif

        // Random traffic with random backpressure; inputs held while stalled
        do_reset();
        last_acc = 1;
        for (int i = 0; i < 600; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = WIDTH'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
                s        = $urandom_range(0, 1);
            end
            out1_ready = ($urandom_range(0, 2) != 0);
            out2_ready = ($urandom_range(0, 3) == 0);
            cycle();
        end
        in_valid = 0;
        out1_ready = 1;
        out2_ready = 1;
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
